funcion_activacion_pwl_pipe: RTL and testbench
==============================================

// Module: funcion_activacion_pwl_pipe
// PURPOSE
//  Pipelined, run-time programmable piecewise-linear (PWL) activation unit: y = M[s]*x + B[s].
//  Segment s is selected by comparing x against ascending breakpoints.
//  Sits between the neuron MAC accumulator and the next layer input.
//  Generalises the fixed-coefficient combinational activation block with: parametric segment count,
//  a programmable coefficient table, a valid/ready stream, backpressure, saturation and bypass.
// PARAMETERS
//  Width     32  signed fixed-point word width (input, output, coefficients)
//  Precision 24  fractional bits; Q(Width-Precision-1).Precision two's complement
//  Segments  32  number of segments, power of 2, >=2; breakpoints used = Segments-1
//  SegBits   5   = clog2(Segments); derived, never overridden
// PORTS
//  CLK       in   1        single clock; all state on rising edge
//  RST_n     in   1        asynchronous active-low reset
//  CFG_WE    in   1        table write strobe, one word per cycle
//  CFG_SEL   in   2        00 breakpoint A, 01 slope M, 10 intercept B, 11 ignored
//  CFG_ADDR  in   SegBits  table index; A uses 0..Segments-2, A[Segments-1] write ignored
//  CFG_DATA  in   Width    signed coefficient
//  Enable    in   1        1 = PWL, 0 = bypass (Salida=Entrada); sampled with the input beat
//  IN_VALID  in   1        input beat valid
//  IN_READY  out  1        unit accepts beat this cycle
//  Entrada   in   Width    signed x
//  OUT_VALID out  1        Salida/Error valid
//  OUT_READY in   1        downstream accepts
//  Salida    out  Width    signed y, saturated
//  Error     out  1        1 = y saturated (overflow of M*x+B), qualified by OUT_VALID
// BEHAVIOUR
//  Reset: all valid bits 0, Salida=0, Error=0, entire A/M/B table = 0. Applies mid-stream:
//   in-flight beats are discarded, no OUT_VALID after release until new input.
//  Handshake: beat accepted when IN_VALID&&IN_READY; output consumed when OUT_VALID&&OUT_READY.
//   OUT_VALID, Salida and Error are held stable while OUT_VALID && !OUT_READY.
//  Stall: stall = OUT_VALID && !OUT_READY; IN_READY = !stall; whole pipe holds on stall.
//   Bubbles collapse only on stall-free cycles (no partial compaction).
//  Latency: 3 cycles accept->OUT_VALID with OUT_READY=1; throughput 1 beat/cycle.
//  S1 (select): s = count of i in 0..Segments-2 with x >= A[i]. Breakpoints are ascending by
//   contract. x below A[0] -> s=0; x >= A[Segments-2] -> s=Segments-1.
//   x == A[i] belongs to the upper segment. Register x, M[s], B[s], Enable, valid.
//  S2 (multiply): p = M*x, full 2*Width signed product, registered.
//  S3 (add/sat):
//   - q = p >>> Precision (arithmetic shift, truncation toward -inf).
//   - r = q + sign-extended B, computed at 2*Width.
//   - r > 2^(Width-1)-1 -> Salida = max positive, Error=1.
//   - r < -2^(Width-1) -> Salida = min negative, Error=1.
//   - otherwise Salida = r[Width-1:0], Error=0.
//   - Bypass beat: Salida=x, Error=0, same 3-cycle latency; order always preserved.
//  Config: CFG writes land at the clock edge, at any time, including during a stall.
//   A beat uses the table contents seen in its S1 cycle; coefficients captured there are immune
//   to later writes. A write and a read of the same entry in one cycle: the read sees the old value.
//  Breakpoints not ascending: no check. s is still the comparison count; Error is not raised.
// STRUCTURE
//  funcion_activacion_pkg:
//   - CFG_SEL encodings (SEL_A, SEL_M, SEL_B)
//   - clog2 function
//   - sat_signed function: 2W -> W saturate, returns value and overflow
//  Sub-module comparador_segmento (combinational, Width/Segments parametric):
//   - in: x and packed A vector; out: SegBits index
//   - implemented as a parallel-compare population count
//  Top holds: the table register arrays, the 3-stage pipe registers, and the stall logic.
// TESTING
//  1 Reset: hold RST_n=0, drive IN_VALID=1 -> OUT_VALID=0, Salida=0, Error=0.
//    After release, with table all zero, x=5.0 -> y=0 three cycles later.
//  2 Identity segment: program all M=1.0 (0x01000000), B=0, A ascending.
//    Stream x=-3.5, 0, 2.25 back-to-back -> y equals x, 3-cycle latency, 1 beat/cycle.
//  3 Boundary select: A[3]=1.0, M[3]=0, B[3]=0x0100_0000, M[4]=0, B[4]=0x0200_0000.
//    x=1.0-2^-24 -> 1.0; x=1.0 -> 2.0; x below A[0] selects s=0; x at max selects s=Segments-1.
//  4 Saturation: M=64.0, B=0, x=100.0 -> Salida=0x7FFFFFFF, Error=1.
//    x=-100.0 -> 0x80000000, Error=1; x=0.5 -> 32.0, Error=0.
//  5 Backpressure: 6-beat stream with OUT_READY toggled 1,0,0,1,0,1...
//    -> no loss, no duplicate, order kept; outputs stable while stalled; IN_READY=0 in stall cycles.
//  6 Mid-flight effects:
//   - CFG write to M[s] one cycle after a beat enters -> that beat uses the old M, the next beat the new.
//   - Enable=0 beat interleaved -> passes x unchanged.
//   - RST_n pulsed with 3 beats in flight -> all dropped.

Source files
------------

// File: rtl/funcion_activacion_pkg.sv
// Shared definitions for the PWL activation unit: table-select codes,
// a constant clog2 and the 2W -> W signed saturation helper.
package funcion_activacion_pkg;

  // CFG_SEL encodings; 2'b11 is ignored by the table
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_M = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;

  // Widest datapath word the saturation helper supports
  localparam int unsigned MAX_W = 64;

  // Saturation result: overflow flag plus the clamped value, sign-extended to MAX_W
  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } sat_t;

  // Ceiling log2 for elaboration-time sizing
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed 2*MAX_W value into a signed w-bit range
  function automatic sat_t sat_signed(input logic signed [2*MAX_W-1:0] r,
                                      input int unsigned            w);
    logic signed [2*MAX_W-1:0] maxv;
    logic signed [2*MAX_W-1:0] minv;
    sat_t                      o;
    maxv  = ((2*MAX_W)'(1) << (w - 1)) - (2*MAX_W)'(1);
    minv  = ~maxv;
    o.ovf = 1'b0;
    o.val = r[MAX_W-1:0];
    if (r > maxv) begin
      o.ovf = 1'b1;
      o.val = maxv[MAX_W-1:0];
    end else if (r < minv) begin
      o.ovf = 1'b1;
      o.val = minv[MAX_W-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/funcion_activacion_pwl_pipe_comparador_segmento.sv
// Segment selector: counts the breakpoints that x reaches (x >= A[i]).
// Ports: x (signed input word), a_vec (packed A[0..Segments-2], A[0] in the LSBs),
//        seg_c (combinational segment index).
module comparador_segmento
  import funcion_activacion_pkg::*;
#(
  parameter  int unsigned Width    = 32,
  parameter  int unsigned Segments = 32,
  localparam int unsigned SegBits  = clog2(Segments)
) (
  input  logic [Width-1:0]              x,
  input  logic [(Segments-1)*Width-1:0] a_vec,
  output logic [SegBits-1:0]            seg_c
);

  // Parallel compares summed; ties go to the upper segment
  always_comb begin
    seg_c = '0;
    for (int unsigned i = 0; i < Segments - 1; i++) begin
      if ($signed(x) >= $signed(a_vec[i*Width +: Width])) seg_c = seg_c + SegBits'(1);
    end
  end

endmodule

// File: rtl/funcion_activacion_pwl_pipe.sv
// Pipelined programmable piecewise-linear activation: y = M[s]*x + B[s], saturated.
// Stages: S1 select+table read, S2 multiply, S3 shift/add/saturate (or bypass).
// Ports:
//   CLK, RST_n                      clock, async active-low reset
//   CFG_WE/CFG_SEL/CFG_ADDR/CFG_DATA table write port (A, M, B)
//   Enable                          1 = PWL, 0 = pass x through
//   IN_VALID/IN_READY/Entrada       input stream
//   OUT_VALID/OUT_READY/Salida/Error output stream; Error flags saturation
module funcion_activacion_pwl_pipe
  import funcion_activacion_pkg::*;
#(
  parameter  int unsigned Width     = 32,
  parameter  int unsigned Precision = 24,
  parameter  int unsigned Segments  = 32,
  localparam int unsigned SegBits   = clog2(Segments)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               CFG_WE,
  input  logic [1:0]         CFG_SEL,
  input  logic [SegBits-1:0] CFG_ADDR,
  input  logic [Width-1:0]   CFG_DATA,
  input  logic               Enable,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [Width-1:0]   Entrada,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [Width-1:0]   Salida,
  output logic               Error
);

  localparam int unsigned PW = 2 * Width;

  // Coefficient tables
  logic [Width-1:0] a_tab [Segments-1];
  logic [Width-1:0] m_tab [Segments];
  logic [Width-1:0] b_tab [Segments];

  logic [(Segments-1)*Width-1:0] a_vec;
  logic [SegBits-1:0]            seg_c;
  logic                          stall_c;

  // Pipe registers
  logic                 v1, v2;
  logic [Width-1:0]     x1, m1, b1;
  logic                 en1;
  logic signed [PW-1:0] p2;
  logic [Width-1:0]     x2, b2;
  logic                 en2;

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] q_c;
  logic signed [PW-1:0] r_c;
  sat_t                 sat_c;

  // Whole pipe freezes while the held output is not taken
  assign stall_c  = OUT_VALID && !OUT_READY;
  assign IN_READY = !stall_c;

  always_comb begin
    a_vec = '0;
    for (int unsigned i = 0; i < Segments - 1; i++) a_vec[i*Width +: Width] = a_tab[i];
  end

  comparador_segmento #(
    .Width    (Width),
    .Segments (Segments)
  ) u_comparador (
    .x     (Entrada),
    .a_vec (a_vec),
    .seg_c (seg_c)
  );

  // Table writes; independent of the pipe, so they also land during stalls
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 0; i < Segments - 1; i++) a_tab[i] <= '0;
      for (int unsigned i = 0; i < Segments; i++) begin
        m_tab[i] <= '0;
        b_tab[i] <= '0;
      end
    end else if (CFG_WE) begin
      case (CFG_SEL)
        SEL_A: if (CFG_ADDR < SegBits'(Segments - 1)) a_tab[CFG_ADDR] <= CFG_DATA;
        SEL_M: m_tab[CFG_ADDR] <= CFG_DATA;
        SEL_B: b_tab[CFG_ADDR] <= CFG_DATA;
        default: ;
      endcase
    end
  end

  // S2 product and S3 arithmetic
  always_comb begin
    prod_c = PW'($signed(m1)) * PW'($signed(x1));
    q_c    = p2 >>> Precision;
    r_c    = q_c + PW'($signed(b2));
    sat_c  = sat_signed((2*MAX_W)'(r_c), Width);
  end

  // Above Width the clamped value only carries sign copies
  if (Width < MAX_W) begin : g_fold
    logic unused_hi;
    assign unused_hi = ^sat_c.val[MAX_W-1:Width];
  end

  // Three-stage pipe; the table is read combinationally in the accept cycle
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      v1        <= 1'b0;
      x1        <= '0;
      m1        <= '0;
      b1        <= '0;
      en1       <= 1'b0;
      v2        <= 1'b0;
      p2        <= '0;
      x2        <= '0;
      b2        <= '0;
      en2       <= 1'b0;
      OUT_VALID <= 1'b0;
      Salida    <= '0;
      Error     <= 1'b0;
    end else if (!stall_c) begin
      v1        <= IN_VALID;
      x1        <= Entrada;
      m1        <= m_tab[seg_c];
      b1        <= b_tab[seg_c];
      en1       <= Enable;
      v2        <= v1;
      p2        <= prod_c;
      x2        <= x1;
      b2        <= b1;
      en2       <= en1;
      OUT_VALID <= v2;
      if (v2) begin
        if (en2) begin
          Salida <= sat_c.val[Width-1:0];
          Error  <= sat_c.ovf;
        end else begin
          Salida <= x2;
          Error  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_funcion_activacion_pwl_pipe.sv
// Bench for funcion_activacion_pwl_pipe: directed scenarios plus random traffic,
// checked against a queue-based arithmetic model of the activation.
module tb_funcion_activacion_pwl_pipe;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 64'sd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] entrada;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] salida;
  logic        error;

  funcion_activacion_pwl_pipe dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .CFG_WE    (cfg_we),
    .CFG_SEL   (cfg_sel),
    .CFG_ADDR  (cfg_addr),
    .CFG_DATA  (cfg_data),
    .Enable    (enable),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .Entrada   (entrada),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .Salida    (salida),
    .Error     (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit lat_chk     = 1'b0;

  typedef struct {
    int y;
    bit e;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  int a_m [32];
  int m_m [32];
  int b_m [32];

  bit          prev_stall = 1'b0;
  logic [31:0] prev_y;
  logic        prev_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // y = M[s]*x + B[s] with s = number of breakpoints at or below x, clamped to 32 bits
  function automatic void model(input int x, input bit en, output int y, output bit e);
    int     s;
    longint p, q, r;
    if (!en) begin
      y = x;
      e = 1'b0;
      return;
    end
    s = 0;
    for (int i = 0; i < 31; i++) if (x >= a_m[i]) s++;
    p = longint'(m_m[s]) * longint'(x);
    q = p >>> 24;
    r = q + longint'(b_m[s]);
    if (r > MAXV) begin
      y = int'(MAXV);
      e = 1'b1;
    end else if (r < MINV) begin
      y = int'(MINV);
      e = 1'b1;
    end else begin
      y = int'(r);
      e = 1'b0;
    end
  endfunction

  // Compare process: checks outputs, then books accepted beats and table writes
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        a_m[i] = 0;
        m_m[i] = 0;
        b_m[i] = 0;
      end
      prev_stall = 1'b0;
      chk(!out_valid && salida == 32'd0 && !error, "reset_outputs",
          longint'({out_valid, error, salida}), 0);
    end else begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready", longint'(in_ready),
          longint'(!(out_valid && !out_ready)));
      if (prev_stall)
        chk(out_valid && salida == prev_y && error == prev_e, "stall_hold",
            longint'({out_valid, error, salida}), longint'({1'b1, prev_e, prev_y}));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", longint'(salida), 0);
        end else begin
          chk(salida == exp_q[0].y, "salida", longint'(salida), longint'(unsigned'(exp_q[0].y)));
          chk(error == exp_q[0].e, "error", longint'(error), longint'(exp_q[0].e));
          if (out_ready) begin
            if (lat_chk) chk(cyc - exp_q[0].acc == 3, "latency", cyc - exp_q[0].acc, 3);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = salida;
      prev_e     = error;
      if (in_valid && in_ready) begin
        exp_t t;
        model(int'(entrada), enable, t.y, t.e);
        t.acc = cyc;
        exp_q.push_back(t);
      end
      if (cfg_we) begin
        case (cfg_sel)
          2'b00: if (cfg_addr < 5'd31) a_m[cfg_addr] = int'(cfg_data);
          2'b01: m_m[cfg_addr] = int'(cfg_data);
          2'b10: b_m[cfg_addr] = int'(cfg_data);
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input int addr, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = 5'(addr);
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // One isolated beat with a hand-computed expected result
  task automatic run_one(input logic [31:0] x, input bit en, input logic [31:0] ey,
                         input bit ee, input string nm);
    bit found;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    entrada   = x;
    enable    = en;
    tick();
    in_valid = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(1'b0, {nm, "_timeout"}, 0, 1);
    else begin
      chk(salida == ey, nm, longint'(salida), longint'(ey));
      chk(error == ee, {nm, "_err"}, longint'(error), longint'(ee));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int          y;
    bit          e;
    int          sent;
    bit          acc;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] xs [6] = '{32'h0100_0000, 32'hFF00_0000, 32'h0080_0000,
                            32'h0300_0000, 32'hFE40_0000, 32'h0000_0001};

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = 2'b00;
    cfg_addr  = '0;
    cfg_data  = '0;
    enable    = 1'b1;
    in_valid  = 1'b1;
    entrada   = 32'h0500_0000;
    out_ready = 1'b1;

    // Reset held with a valid input offered, then a beat on the all-zero table
    repeat (4) tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    run_one(32'h0500_0000, 1'b1, 32'h0, 1'b0, "t1_zero_table");

    // Identity on every segment, breakpoints A[i] = i-2
    for (int i = 0; i < 32; i++) begin
      cfg(2'b01, i, 32'h0100_0000);
      cfg(2'b10, i, 32'h0);
    end
    for (int i = 0; i < 31; i++) cfg(2'b00, i, 32'((i - 2) * 16777216));
    lat_chk = 1'b1;
    foreach (xs[i]) begin
      if (i > 2) break;
      in_valid = 1'b1;
      enable   = 1'b1;
      entrada  = (i == 0) ? 32'hFC80_0000 : (i == 1) ? 32'h0 : 32'h0240_0000;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    lat_chk = 1'b0;
    model(int'(32'hFC80_0000), 1'b1, y, e);
    chk(y == int'(32'hFC80_0000) && !e, "model_identity", longint'(y), 64'hFFFF_FFFF_FC80_0000);

    // Boundary select
    cfg(2'b01, 3, 32'h0);
    cfg(2'b10, 3, 32'h0100_0000);
    cfg(2'b01, 4, 32'h0);
    cfg(2'b10, 4, 32'h0200_0000);
    cfg(2'b01, 0, 32'h0);
    cfg(2'b10, 0, 32'h0003_0000);
    cfg(2'b01, 31, 32'h0);
    cfg(2'b10, 31, 32'h0007_0000);
    run_one(32'h00FF_FFFF, 1'b1, 32'h0100_0000, 1'b0, "t3_below_bp");
    run_one(32'h0100_0000, 1'b1, 32'h0200_0000, 1'b0, "t3_at_bp");
    run_one(32'h9C00_0000, 1'b1, 32'h0003_0000, 1'b0, "t3_seg_lo");
    run_one(32'h7FFF_FFFF, 1'b1, 32'h0007_0000, 1'b0, "t3_seg_hi");

    // Saturation with slope 64.0
    for (int i = 0; i < 32; i++) begin
      cfg(2'b01, i, 32'h4000_0000);
      cfg(2'b10, i, 32'h0);
    end
    run_one(32'h6400_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, "t4_sat_pos");
    run_one(32'h9C00_0000, 1'b1, 32'h8000_0000, 1'b1, "t4_sat_neg");
    run_one(32'h0080_0000, 1'b1, 32'h2000_0000, 1'b0, "t4_no_sat");

    // Backpressure: six beats under a 1,0,0,1,0,1 ready pattern
    for (int i = 0; i < 32; i++) cfg(2'b01, i, 32'h0100_0000);
    sent = 0;
    for (int k = 0; k < 60 && (sent < 6 || exp_q.size() != 0); k++) begin
      out_ready = pat[k % 6];
      in_valid  = (sent < 6);
      entrada   = xs[sent % 6];
      enable    = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    chk(sent == 6, "t5_sent", sent, 6);
    drain();

    // Coefficient write one cycle after a beat enters (x=0.5 sits in segment 3)
    in_valid = 1'b1;
    entrada  = 32'h0080_0000;
    enable   = 1'b1;
    tick();
    cfg_we   = 1'b1;
    cfg_sel  = 2'b01;
    cfg_addr = 5'd3;
    cfg_data = 32'h0200_0000;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    drain();
    run_one(32'h0080_0000, 1'b1, 32'h0100_0000, 1'b0, "t6_new_m");
    run_one(32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, "t6_bypass");

    // Reset with three beats in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      entrada = 32'(i) << 24;
      tick();
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(!out_valid, "t6_reset_drop", longint'(out_valid), 0);
    end
    tick();

    // Random traffic with interleaved bypass, stalls and table writes
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) entrada = $urandom;
      else entrada = (32'($urandom_range(0, 40)) << 24) - 32'h0600_0000
                     + 32'($urandom_range(0, 2)) - 32'd1;
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_addr = 5'($urandom_range(0, 31));
      cfg_data = ($urandom_range(0, 1) == 1) ? $urandom
                                             : 32'($signed($urandom) >>> 5);
      tick();
    end
    cfg_we = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
